// File: rtl/dac_seq_pkg.sv
// Shared VGA 640x480 timing constants, pattern-mode encodings and the active-region
// pattern generator used by the DAC frame sequencer.
package dac_seq_pkg;

  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] H_FP     = 10'd16;
  localparam logic [9:0] H_SYNC   = 10'd96;
  localparam logic [9:0] H_BP     = 10'd48;
  localparam logic [9:0] H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [9:0] V_FP     = 10'd10;
  localparam logic [9:0] V_SYNC   = 10'd2;
  localparam logic [9:0] V_BP     = 10'd33;
  localparam logic [9:0] V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] CAL_LINE = 10'd500;
  localparam logic [9:0] CAL_LEN  = 10'd256;

  localparam logic [2:0] MODE_BLACK   = 3'd0;
  localparam logic [2:0] MODE_HRAMP   = 3'd1;
  localparam logic [2:0] MODE_VRAMP   = 3'd2;
  localparam logic [2:0] MODE_CHECKER = 3'd3;
  localparam logic [2:0] MODE_XOR     = 3'd4;
  localparam logic [2:0] MODE_ANIM    = 3'd5;

  // Code for a visible pixel; reserved modes fall through to black.
  function automatic logic [7:0] pattern_code(input logic [2:0] mode,
                                              input logic [9:0] h,
                                              input logic [9:0] v,
                                              input logic [7:0] frame);
    logic [7:0] code;
    code = 8'h00;
    case (mode)
      MODE_HRAMP:   code = h[7:0];
      MODE_VRAMP:   code = v[7:0];
      MODE_CHECKER: code = (h[5] ^ v[5]) ? 8'hFF : 8'h00;
      MODE_XOR:     code = h[7:0] ^ v[7:0];
      MODE_ANIM:    code = h[7:0] + frame;
      default:      code = 8'h00;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Free-running pixel (h) and line (v) counters with a one-cycle frame-wrap pulse
// that is high while the counters sit on the last pixel of the last line.
module vga_timing_counter #(
  parameter logic [9:0] H_TOTAL = dac_seq_pkg::H_TOTAL,
  parameter logic [9:0] V_TOTAL = dac_seq_pkg::V_TOTAL
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       frame_wrap
);

  logic h_last;
  logic v_last;

  assign h_last     = (h == H_TOTAL - 10'd1);
  assign v_last     = (v == V_TOTAL - 10'd1);
  assign frame_wrap = h_last && v_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      h <= 10'd0;
      v <= 10'd0;
    end else if (h_last) begin
      h <= 10'd0;
      v <= v_last ? 10'd0 : v + 10'd1;
    end else begin
      h <= h + 10'd1;
    end
  end

endmodule

// File: rtl/dac_frame_sequencer.sv
// Video DAC sequencer: VGA timing decode, frame-synchronous pattern/calibration
// selection and one registered output stage feeding the complementary DAC rails.
module dac_frame_sequencer
  import dac_seq_pkg::*;
#(
  parameter logic [9:0] H_ACTIVE_P = dac_seq_pkg::H_ACTIVE,
  parameter logic [9:0] H_FP_P     = dac_seq_pkg::H_FP,
  parameter logic [9:0] H_SYNC_P   = dac_seq_pkg::H_SYNC,
  parameter logic [9:0] H_BP_P     = dac_seq_pkg::H_BP,
  parameter logic [9:0] V_ACTIVE_P = dac_seq_pkg::V_ACTIVE,
  parameter logic [9:0] V_FP_P     = dac_seq_pkg::V_FP,
  parameter logic [9:0] V_SYNC_P   = dac_seq_pkg::V_SYNC,
  parameter logic [9:0] V_BP_P     = dac_seq_pkg::V_BP,
  parameter logic [9:0] CAL_LINE_P = dac_seq_pkg::CAL_LINE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] mode_in,
  input  logic       cal_en,
  output logic [7:0] dac_p,
  output logic [7:0] dac_n,
  output logic       hsync,
  output logic       vsync,
  output logic       hblank,
  output logic       vblank,
  output logic       cal_strobe,
  output logic [7:0] frame_cnt
);

  localparam logic [9:0] HT       = H_ACTIVE_P + H_FP_P + H_SYNC_P + H_BP_P;
  localparam logic [9:0] VT       = V_ACTIVE_P + V_FP_P + V_SYNC_P + V_BP_P;
  localparam logic [9:0] HS_START = H_ACTIVE_P + H_FP_P;
  localparam logic [9:0] HS_END   = H_ACTIVE_P + H_FP_P + H_SYNC_P;
  localparam logic [9:0] VS_START = V_ACTIVE_P + V_FP_P;
  localparam logic [9:0] VS_END   = V_ACTIVE_P + V_FP_P + V_SYNC_P;

  logic [9:0] h;
  logic [9:0] v;
  logic       frame_wrap;

  logic [2:0] mode_q;
  logic       cal_q;
  logic [7:0] code_q;

  logic       hblank_d;
  logic       vblank_d;
  logic       hsync_d;
  logic       vsync_d;
  logic       strobe_d;
  logic [7:0] code_d;

  vga_timing_counter #(
    .H_TOTAL (HT),
    .V_TOTAL (VT)
  ) u_timing (
    .clk        (clk),
    .rst        (rst),
    .h          (h),
    .v          (v),
    .frame_wrap (frame_wrap)
  );

  always_comb begin
    hblank_d = (h >= H_ACTIVE_P);
    vblank_d = (v >= V_ACTIVE_P);
    hsync_d  = !((h >= HS_START) && (h < HS_END));
    vsync_d  = !((v >= VS_START) && (v < VS_END));
    code_d   = 8'h00;
    strobe_d = 1'b0;
    // The calibration ramp lives in vertical blanking, so it must win over blanking.
    if (cal_q && (v == CAL_LINE_P) && (h < CAL_LEN)) begin
      code_d   = h[7:0];
      strobe_d = 1'b1;
    end else if (hblank_d || vblank_d) begin
      code_d = 8'h00;
    end else begin
      code_d = pattern_code(mode_q, h, v, frame_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= MODE_BLACK;
      cal_q      <= 1'b0;
      frame_cnt  <= 8'h00;
      code_q     <= 8'h00;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      hblank     <= 1'b1;
      vblank     <= 1'b1;
      cal_strobe <= 1'b0;
    end else begin
      if (frame_wrap) begin
        mode_q    <= mode_in;
        cal_q     <= cal_en;
        frame_cnt <= frame_cnt + 8'h01;
      end
      code_q     <= code_d;
      hsync      <= hsync_d;
      vsync      <= vsync_d;
      hblank     <= hblank_d;
      vblank     <= vblank_d;
      cal_strobe <= strobe_d;
    end
  end

  // Both rails come from the single code register so they can never disagree.
  assign dac_p = code_q;
  assign dac_n = ~code_q;

endmodule

// File: tb/tb_dac_frame_sequencer.sv
// Directed bench: a shrunken-timing instance walks whole frames; a default-timing
// instance checks the real 640x480 line timing on its first line.
module tb_dac_frame_sequencer;

  localparam int HT = 320;
  localparam int VT = 27;
  localparam int FR = HT * VT;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] mode_in;
  logic       cal_en;
  logic [7:0] dac_p, dac_n, frame_cnt;
  logic       hsync, vsync, hblank, vblank, cal_strobe;

  logic [2:0] f_mode;
  logic       f_cal;
  logic [7:0] f_dac_p, f_dac_n, f_frame_cnt;
  logic       f_hsync, f_vsync, f_hblank, f_vblank, f_cal_strobe;

  int n_total = 0;
  int n_bad   = 0;
  int idx     = -1;
  int cycles  = 0;

  always #5 clk = ~clk;

  dac_frame_sequencer #(
    .H_ACTIVE_P (10'd300), .H_FP_P (10'd4), .H_SYNC_P (10'd8), .H_BP_P (10'd8),
    .V_ACTIVE_P (10'd20),  .V_FP_P (10'd2), .V_SYNC_P (10'd2), .V_BP_P (10'd3),
    .CAL_LINE_P (10'd24)
  ) dut (
    .clk (clk), .rst (rst), .mode_in (mode_in), .cal_en (cal_en),
    .dac_p (dac_p), .dac_n (dac_n), .hsync (hsync), .vsync (vsync),
    .hblank (hblank), .vblank (vblank), .cal_strobe (cal_strobe),
    .frame_cnt (frame_cnt)
  );

  dac_frame_sequencer dut_full (
    .clk (clk), .rst (rst), .mode_in (f_mode), .cal_en (f_cal),
    .dac_p (f_dac_p), .dac_n (f_dac_n), .hsync (f_hsync), .vsync (f_vsync),
    .hblank (f_hblank), .vblank (f_vblank), .cal_strobe (f_cal_strobe),
    .frame_cnt (f_frame_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (idx=%0d)", tag, obs, exp, idx);
    end
  endtask

  // idx is the counter state (v*HT+h, frame-continuous) shown on the outputs.
  task automatic tick();
    @(posedge clk);
    if (rst) idx = -1;
    else idx++;
    @(negedge clk);
    cycles++;
    if (cycles > 90000) begin
      $display("FAIL cycle_budget: got %0d expected <=90000", cycles);
      $fatal(1, "cycle budget exceeded");
    end
  endtask

  task automatic run_to(input int target);
    while (idx < target) tick();
  endtask

  function automatic int at(input int f, input int v, input int h);
    return f * FR + v * HT + h;
  endfunction

  initial begin
    int n_inv, n_nz, s_hs, s_hs_first, s_hb, vs_cnt, vs_first, vb_first;
    int f_hs, f_hs_first, f_hb, f_hb_first, f_inv;
    int ramp_err, strobe_cnt;
    logic [7:0] exp_code;

    rst = 1'b1; mode_in = 3'd0; cal_en = 1'b0; f_mode = 3'd0; f_cal = 1'b0;
    @(negedge clk);
    repeat (3) tick();

    check("rst_dac_p", dac_p, 8'h00);
    check("rst_dac_n", dac_n, 8'hFF);
    check("rst_syncs", {hsync, vsync}, 2'b11);
    check("rst_blanks", {hblank, vblank}, 2'b11);
    check("rst_strobe", cal_strobe, 1'b0);
    check("rst_frame_cnt", frame_cnt, 8'h00);
    check("rst_full_dac_n", f_dac_n, 8'hFF);

    rst = 1'b0;
    tick();
    check("rel_blanks", {hblank, vblank}, 2'b00);
    check("rel_syncs", {hsync, vsync}, 2'b11);
    check("rel_full_hblank", f_hblank, 1'b0);

    // Frame 0: mode change mid-frame must not show until the wrap.
    n_inv = 0; n_nz = 0; s_hs = 0; s_hs_first = -1; s_hb = 0;
    vs_cnt = 0; vs_first = -1; vb_first = -1;
    f_hs = 0; f_hs_first = -1; f_hb = 0; f_hb_first = -1; f_inv = 0;
    while (idx < FR) begin
      if (dac_n !== ~dac_p) n_inv++;
      if (dac_p !== 8'h00) n_nz++;
      if (idx < HT) begin
        if (!hsync) begin
          s_hs++;
          if (s_hs_first < 0) s_hs_first = idx;
        end
        if (hblank) s_hb++;
      end
      if (!vsync) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = idx;
      end
      if (vblank && vb_first < 0) vb_first = idx;
      if (idx < 800) begin
        if (f_dac_n !== ~f_dac_p) f_inv++;
        if (!f_hsync) begin
          f_hs++;
          if (f_hs_first < 0) f_hs_first = idx;
        end
        if (f_hblank) begin
          f_hb++;
          if (f_hb_first < 0) f_hb_first = idx;
        end
      end
      if (idx == FR - 2) check("fc_before_wrap", frame_cnt, 8'd0);
      if (idx == FR - 1) check("fc_at_wrap", frame_cnt, 8'd1);
      if (idx == 100) mode_in = 3'd1;
      tick();
    end
    check("f0_dac_n_inv", n_inv, 0);
    check("f0_black_held", n_nz, 0);
    check("hsync_low_cnt", s_hs, 8);
    check("hsync_first", s_hs_first, 304);
    check("hblank_cnt", s_hb, 20);
    check("vsync_low_cnt", vs_cnt, 640);
    check("vsync_first", vs_first, 7040);
    check("vblank_first", vb_first, 6400);
    check("full_hsync_low_cnt", f_hs, 96);
    check("full_hsync_first", f_hs_first, 656);
    check("full_hblank_cnt", f_hb, 160);
    check("full_hblank_first", f_hb_first, 640);
    check("full_dac_n_inv", f_inv, 0);

    // Frame 1: horizontal ramp on line 10.
    run_to(at(1, 10, 0));
    ramp_err = 0; n_inv = 0;
    for (int h = 0; h < HT; h++) begin
      exp_code = (h < 300) ? 8'(h) : 8'h00;
      if (dac_p !== exp_code) ramp_err++;
      if (dac_n !== ~dac_p) n_inv++;
      if (h == 5) check("m1_h5", dac_p, 8'h05);
      if (h == 299) check("m1_h299", dac_p, 8'h2B);
      if (h == 300) check("m1_h300_blank", dac_p, 8'h00);
      tick();
    end
    check("m1_line_errors", ramp_err, 0);
    check("m1_dac_n_inv", n_inv, 0);
    check("m1_frame_cnt", frame_cnt, 8'd1);
    run_to(at(1, 15, 0));
    mode_in = 3'd3;
    run_to(at(1, 18, 7));
    check("m1_not_torn", dac_p, 8'h07);

    // Frame 2: checkerboard from the first cycle.
    run_to(at(2, 0, 0));
    check("m3_first_cycle", dac_p, 8'h00);
    check("m3_frame_cnt", frame_cnt, 8'd2);
    run_to(at(2, 0, 32));
    check("m3_h32", dac_p, 8'hFF);
    run_to(at(2, 1, 70));
    check("m3_h70", dac_p, 8'h00);
    run_to(at(2, 1, 100));
    check("m3_h100", dac_p, 8'hFF);
    cal_en = 1'b1; mode_in = 3'd5;
    run_to(at(2, 24, 10));
    check("cal_not_yet_code", dac_p, 8'h00);
    check("cal_not_yet_strobe", cal_strobe, 1'b0);

    // Frame 3: animated ramp and the calibration line.
    run_to(at(3, 1, 10));
    check("m5_h10", dac_p, 8'h0D);
    check("m5_frame_cnt", frame_cnt, 8'd3);
    run_to(at(3, 2, 254));
    check("m5_wrap", dac_p, 8'h01);
    run_to(at(3, 23, 5));
    check("pre_cal_code", dac_p, 8'h00);
    check("pre_cal_strobe", cal_strobe, 1'b0);
    mode_in = 3'd4;
    run_to(at(3, 24, 0));
    ramp_err = 0; strobe_cnt = 0;
    for (int h = 0; h < HT; h++) begin
      exp_code = (h < 256) ? 8'(h) : 8'h00;
      if (dac_p !== exp_code) ramp_err++;
      if (cal_strobe !== (h < 256)) ramp_err++;
      if (cal_strobe) strobe_cnt++;
      if (h == 255) check("cal_h255", dac_p, 8'hFF);
      tick();
    end
    check("cal_ramp_errors", ramp_err, 0);
    check("cal_strobe_cnt", strobe_cnt, 256);
    check("post_cal_strobe", cal_strobe, 1'b0);

    // Frame 4: xor pattern, then a mid-line reset.
    run_to(at(4, 3, 9));
    check("m4_xor", dac_p, 8'h0A);
    run_to(at(4, 5, 100));
    rst = 1'b1;
    tick();
    check("mid_rst_dac_p", dac_p, 8'h00);
    check("mid_rst_dac_n", dac_n, 8'hFF);
    check("mid_rst_sync_blank", {hsync, vsync, hblank, vblank, cal_strobe}, 5'b11110);
    check("mid_rst_frame_cnt", frame_cnt, 8'd0);
    tick();
    rst = 1'b0;
    tick();
    check("after_rst_blanks", {hblank, vblank}, 2'b00);
    check("after_rst_frame_cnt", frame_cnt, 8'd0);
    run_to(10);
    check("after_rst_mode_black", dac_p, 8'h00);
    run_to(24 * HT + 10);
    check("after_rst_cal_off", {cal_strobe, dac_p}, 9'h000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
